mips_halt_monitor: RTL
======================

Name: mips_halt_monitor

Overview:
- Parametrised, synthesisable pass/fail monitor for CPU-level testbenches of mips_cpu_harvard.
- Replaces hand-written per-test halt assertions.
- Watches the CPU's active flag, instruction address and register_v0 each cycle, and detects halt (fetch from HALT_ADDR, or active deasserted).
- After a settle window, compares v0 against an expected value and enforces a cycle timeout, giving a single done/pass/fail_code result per test.

Parameters:
- ADDR_W, 32, width of instr_address.
- DATA_W, 32, width of register_v0 and expected_v0.
- HALT_ADDR, 32'h00000000, fetch address that signals halt.
- SETTLE_CYCLES, 2, enabled cycles to wait after halt detection before sampling v0 (range 0..15).
- TIMEOUT_CYCLES, 1000, enabled cycles allowed from reset release to halt detection.
- CNT_W, 16, width of cycle_count.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  when 0, all state, counters and outputs hold.
- active  in  1  CPU active flag.
- instr_address  in  ADDR_W  CPU fetch address.
- register_v0  in  DATA_W  CPU $v0 debug output.
- expected_v0  in  DATA_W  golden v0 value; must be static for the whole test.
- done  out  1  test finished; sticky until reset.
- pass  out  1  valid only when done=1; 1 = v0 matched.
- fail_code  out  2  0 = none, 1 = v0 mismatch, 2 = timeout, 3 = stall (optional feature).
- cycle_count  out  CNT_W  enabled cycles counted since reset release; saturates at all-ones.
- halt_v0  out  DATA_W  register_v0 value sampled at the end of the settle window.

Behaviour:
- Decided interface facts: one clock, clk. Reset is synchronous and active-high, named reset. Every state update happens on the rising edge of clk.
- Reset values: done=0, pass=0, fail_code=0, cycle_count=0, halt_v0=0, state=WAIT_ACTIVE, settle counter=0.
- Reset asserted mid-test (any state) returns to the reset values on the next edge.
- All transitions and counter updates require clk_enable=1. With clk_enable=0, everything holds.
- cycle_count:
  - increments by 1 on each enabled edge while state is WAIT_ACTIVE, RUN or SETTLE;
  - saturates at 2^CNT_W-1;
  - freezes in DONE.
- States:
  - WAIT_ACTIVE: go to RUN when active=1.
  - RUN: halt condition is (instr_address==HALT_ADDR) or (active=0). On halt, load the settle counter with SETTLE_CYCLES and go to SETTLE.
  - SETTLE: decrement the settle counter each enabled edge. When it is 0 at an edge:
    - latch halt_v0 <= register_v0;
    - done <= 1;
    - if register_v0==expected_v0, then pass <= 1 and fail_code <= 0;
    - otherwise pass <= 0 and fail_code <= 1;
    - go to DONE.
    - With SETTLE_CYCLES=0, the compare happens on the first enabled edge in SETTLE, i.e. one cycle after halt detection.
  - DONE: terminal; all outputs hold until reset.
- Timeout: in WAIT_ACTIVE or RUN, the edge at which cycle_count equals TIMEOUT_CYCLES-1 sets done=1, pass=0, fail_code=2 and goes to DONE.
- Timeout is not checked in SETTLE.
- Priority when halt and timeout occur on the same edge: halt wins.
- The halt check in RUN does not apply in WAIT_ACTIVE. Address 0 before active rises is not a halt.
- pass and fail_code change only on the edge that enters DONE.

Optional Feature:
- Macro MIPS_HALT_MONITOR_STALL_CHECK_EN. Defined: adds parameter STALL_CYCLES (default 64) and a stall counter.
- In RUN the stall counter:
  - resets to 0 whenever instr_address differs from its registered previous value;
  - otherwise increments on each enabled edge.
- When the stall counter reaches STALL_CYCLES-1: done=1, pass=0, fail_code=3, go to DONE.
- Priority: halt > stall > timeout.
- Undefined: no stall logic; fail_code never takes value 3.

Test Plan:
- Pass, two settle cycles:
  - stimulus: reset 2 cycles; active=1; instr_address steps 0xBFC00000, 0xBFC00004, 0xBFC00008, then 0x0; register_v0=2, expected_v0=2.
  - response: done=1, pass=1, fail_code=0, halt_v0=2, exactly 3 enabled cycles after the first cycle with address 0x0.
- Mismatch:
  - stimulus: same sequence with register_v0=1, expected_v0=2.
  - response: done=1, pass=0, fail_code=1, halt_v0=1.
- Timeout:
  - stimulus: TIMEOUT_CYCLES=20; active=1; address cycles 0xBFC00000/0xBFC00004, never reaching 0.
  - response: done=1, fail_code=2, cycle_count=19; outputs unchanged for 10 more cycles.
- Clock enable gating:
  - stimulus: pass scenario with clk_enable=0 for 5 cycles during SETTLE.
  - response: done is delayed by exactly 5 cycles; cycle_count does not advance during the gap.
- Reset mid-test:
  - stimulus: assert reset for 1 cycle while in SETTLE, then rerun the pass scenario.
  - response: all outputs 0 the edge after reset; second run gives pass=1.
- Stall (macro defined):
  - stimulus: STALL_CYCLES=8; address held at 0xBFC00004 with active=1.
  - response: fail_code=3 on the 8th enabled edge after the address stops changing.

Source files
------------

// File: rtl/mips_halt_monitor.sv
// Pass/fail monitor for mips_cpu_harvard CPU-level testbenches.
// Detects halt (fetch from HALT_ADDR, or active dropping), waits a settle window, then
// compares register_v0 against expected_v0. A cycle timeout catches runaway programs.
// Optional stall detection is compiled in when MIPS_HALT_MONITOR_STALL_CHECK_EN is defined.
// cycle_count counts the enabled edges spent before the edge that enters the done state.
module mips_halt_monitor #(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       DATA_W         = 32,
   parameter logic [ADDR_W-1:0] HALT_ADDR      = '0,
   parameter int unsigned       SETTLE_CYCLES  = 2,
   parameter int unsigned       TIMEOUT_CYCLES = 1000,
   parameter int unsigned       CNT_W          = 16
`ifdef MIPS_HALT_MONITOR_STALL_CHECK_EN
   ,
   parameter int unsigned       STALL_CYCLES   = 64
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              active,
   input  logic [ADDR_W-1:0] instr_address,
   input  logic [DATA_W-1:0] register_v0,
   input  logic [DATA_W-1:0] expected_v0,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [DATA_W-1:0] halt_v0
);

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       SettleLoad  = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      StWaitActive,
      StRun,
      StSettle,
      StDone
   } state_e;

   state_e           state;
   logic [3:0]       settle_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             halt_hit;
   logic             timeout_hit;

   // Saturating increment; the counter sticks at all-ones.
   assign cnt_inc     = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
   assign halt_hit    = (instr_address == HALT_ADDR) || !active;
   assign timeout_hit = (cycle_count == TimeoutLast);

`ifdef MIPS_HALT_MONITOR_STALL_CHECK_EN
   localparam int unsigned    StallW    = $clog2(STALL_CYCLES) + 1;
   localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYCLES - 1);

   logic [StallW-1:0] stall_cnt;
   logic [ADDR_W-1:0] prev_addr;
   logic              stall_hit;

   assign stall_hit = (instr_address == prev_addr) && (stall_cnt == StallLast);

   // Stall tracking: count consecutive RUN edges on which the fetch address did not move.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         prev_addr <= '0;
      end else if (clk_enable) begin
         prev_addr <= instr_address;
         if (state != StRun || instr_address != prev_addr) begin
            stall_cnt <= '0;
         end else if (stall_cnt != StallLast) begin
            stall_cnt <= stall_cnt + StallW'(1);
         end
      end
   end
`endif

   // Monitor FSM with registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StWaitActive;
         settle_cnt  <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_code   <= 2'd0;
         cycle_count <= '0;
         halt_v0     <= '0;
      end else if (clk_enable) begin
         unique case (state)
            StWaitActive: begin
               // Address HALT_ADDR is ignored here; the CPU has not started yet.
               if (timeout_hit) begin
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_code <= 2'd2;
                  state     <= StDone;
               end else begin
                  cycle_count <= cnt_inc;
                  if (active) state <= StRun;
               end
            end
            StRun: begin
               if (halt_hit) begin
                  settle_cnt  <= SettleLoad;
                  cycle_count <= cnt_inc;
                  state       <= StSettle;
`ifdef MIPS_HALT_MONITOR_STALL_CHECK_EN
               end else if (stall_hit) begin
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_code <= 2'd3;
                  state     <= StDone;
`endif
               end else if (timeout_hit) begin
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_code <= 2'd2;
                  state     <= StDone;
               end else begin
                  cycle_count <= cnt_inc;
               end
            end
            StSettle: begin
               // No timeout here: a halted program always gets its v0 compare.
               if (settle_cnt == 4'd0) begin
                  halt_v0 <= register_v0;
                  done    <= 1'b1;
                  if (register_v0 == expected_v0) begin
                     pass      <= 1'b1;
                     fail_code <= 2'd0;
                  end else begin
                     pass      <= 1'b0;
                     fail_code <= 2'd1;
                  end
                  state <= StDone;
               end else begin
                  settle_cnt  <= settle_cnt - 4'd1;
                  cycle_count <= cnt_inc;
               end
            end
            StDone: begin
               state <= StDone;
            end
            default: begin
               state <= StWaitActive;
            end
         endcase
      end
   end

endmodule
